// File: rtl/lfsr64_tick_stepper.sv
// 64-bit Fibonacci LFSR stepped by divider ticks, with a valid/ready output,
// seed loading, lockup guard, overrun reporting and a step counter.
module lfsr64_tick_stepper #(
    parameter logic [63:0] TAPS         = 64'hD800_0000_0000_0000,
    parameter logic [63:0] DEFAULT_SEED = 64'h0000_0000_0000_0001,
    parameter int          CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    input  logic             i_enable,
    input  logic             i_seed_load,
    input  logic [63:0]      i_seed,
    output logic [63:0]      o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_overrun,
    output logic             o_seed_err,
    output logic [CNT_W-1:0] o_steps
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [63:0]      state_q, state_d;
    logic [63:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             seed_err_q, seed_err_d;
    logic [CNT_W-1:0] steps_q, steps_d;

    logic [63:0] next_state;
    logic        slot_free;
    logic        do_step;
    logic        seed_zero;

    // An all-zero state would lock the shifter; restart from the default seed.
    assign next_state = (state_q == 64'd0) ? DEFAULT_SEED
                      : {state_q[62:0], ^(state_q & TAPS)};
    assign slot_free  = !valid_q || i_ready;
    assign seed_zero  = (i_seed == 64'd0);

    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        data_d     = data_q;
        valid_d    = valid_q && !i_ready;
        overrun_d  = 1'b0;
        seed_err_d = 1'b0;
        steps_d    = steps_q;
        do_step    = 1'b0;

        if (i_seed_load) begin
            state_d    = seed_zero ? DEFAULT_SEED : i_seed;
            seed_err_d = seed_zero;
            valid_d    = 1'b0;
            steps_d    = '0;
            fsm_d      = i_enable ? RUN : IDLE;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (i_enable) fsm_d = RUN;
                end
                RUN: begin
                    if (!i_enable) begin
                        fsm_d = IDLE;
                    end else if (i_tick) begin
                        if (slot_free) begin
                            do_step = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                            fsm_d     = STALL;
                        end
                    end
                end
                STALL: begin
                    if (!i_enable) begin
                        fsm_d = IDLE;
                    end else if (i_ready && valid_q) begin
                        fsm_d   = RUN;
                        do_step = i_tick;
                    end else if (i_tick) begin
                        overrun_d = 1'b1;
                    end
                end
                default: fsm_d = IDLE;
            endcase

            if (do_step) begin
                state_d = next_state;
                data_d  = next_state;
                valid_d = 1'b1;
                steps_d = steps_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm_q      <= IDLE;
            state_q    <= DEFAULT_SEED;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            seed_err_q <= 1'b0;
            steps_q    <= '0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            seed_err_q <= seed_err_d;
            steps_q    <= steps_d;
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_overrun  = overrun_q;
    assign o_seed_err = seed_err_q;
    assign o_steps    = steps_q;

endmodule
